// File: rtl/cnn_layer_sequencer_if.sv
// rtl/cnn_layer_sequencer_if.sv - control, pixel-load, engine handshake and FC score signals of the layer sequencer
interface cnn_layer_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int CLASS_WIDTH = 4
);
    logic                   start;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [CLASS_WIDTH-1:0] class_out;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   pix_we;
    logic [ADDR_WIDTH-1:0]  pix_addr;
    logic                   conv_start;
    logic                   conv_done;
    logic                   pool_start;
    logic                   pool_done;
    logic                   fc_start;
    logic                   fc_done;
    logic                   fc_out_valid;
    logic [DATA_WIDTH-1:0]  fc_out_data;

    // master is the sequencer; slave is the host / engine side
    modport master (
        input  start, abort, pix_valid, conv_done, pool_done, fc_done, fc_out_valid, fc_out_data,
        output busy, done, error, class_out, pix_ready, pix_we, pix_addr, conv_start, pool_start, fc_start
    );
    modport slave (
        output start, abort, pix_valid, conv_done, pool_done, fc_done, fc_out_valid, fc_out_data,
        input  busy, done, error, class_out, pix_ready, pix_we, pix_addr, conv_start, pool_start, fc_start
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - CNN inference sequencer: image load, conv/pool/fc start-done handshakes, argmax, watchdog
module cnn_layer_sequencer #(
    parameter int INPUT_SIZE     = 28,
    parameter int FC_NUM_OUTPUTS = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rstb,
    cnn_layer_sequencer_if.master bus
);
    localparam int NUM_PIX = INPUT_SIZE * INPUT_SIZE;
    localparam int ADDR_W  = $clog2(NUM_PIX);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(FC_NUM_OUTPUTS + 2);
    localparam int CLS_W   = $clog2(FC_NUM_OUTPUTS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CONV, S_POOL, S_FC, S_FIN, S_ERR
    } state_t;

    state_t                        state;
    logic                          busy_q, done_q, error_q, pix_ready_q;
    logic                          conv_start_q, pool_start_q, fc_start_q;
    logic [CLS_W-1:0]              class_q, best_idx, best_idx_next;
    logic [ADDR_W-1:0]             pix_cnt;
    logic [CNT_W-1:0]              score_cnt, score_cnt_next;
    logic [WD_W-1:0]               wd;
    logic signed [DATA_WIDTH-1:0]  best_score;
    logic                          pix_we, wd_expired, take;

    assign pix_we         = bus.pix_valid & pix_ready_q;
    assign wd_expired     = (wd == WD_W'(TIMEOUT_CYCLES - 1));
    // strict greater-than keeps the lower index on ties
    assign take           = bus.fc_out_valid &&
                            ((score_cnt == '0) || ($signed(bus.fc_out_data) > best_score));
    assign score_cnt_next = score_cnt + CNT_W'(bus.fc_out_valid);
    assign best_idx_next  = take ? CLS_W'(score_cnt) : best_idx;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state        <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            pix_ready_q  <= 1'b0;
            conv_start_q <= 1'b0;
            pool_start_q <= 1'b0;
            fc_start_q   <= 1'b0;
            class_q      <= '0;
            best_idx     <= '0;
            best_score   <= '0;
            pix_cnt      <= '0;
            score_cnt    <= '0;
            wd           <= '0;
        end else begin
            done_q       <= 1'b0;
            conv_start_q <= 1'b0;
            pool_start_q <= 1'b0;
            fc_start_q   <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state       <= S_IDLE;
                busy_q      <= 1'b0;
                pix_ready_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state       <= S_LOAD;
                            busy_q      <= 1'b1;
                            pix_ready_q <= 1'b1;
                            error_q     <= 1'b0;
                            pix_cnt     <= '0;
                            score_cnt   <= '0;
                            best_idx    <= '0;
                            best_score  <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (pix_we) begin
                            if (pix_cnt == ADDR_W'(NUM_PIX - 1)) begin
                                state        <= S_CONV;
                                pix_ready_q  <= 1'b0;
                                conv_start_q <= 1'b1;
                                wd           <= '0;
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    end
                    // the start register doubles as the first-cycle marker that masks an early done
                    S_CONV: begin
                        if (bus.conv_done && !conv_start_q) begin
                            state        <= S_POOL;
                            pool_start_q <= 1'b1;
                            wd           <= '0;
                        end else if (wd_expired) begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_POOL: begin
                        if (bus.pool_done && !pool_start_q) begin
                            state      <= S_FC;
                            fc_start_q <= 1'b1;
                            wd         <= '0;
                        end else if (wd_expired) begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_FC: begin
                        if (bus.fc_out_valid) begin
                            score_cnt <= score_cnt_next;
                            best_idx  <= best_idx_next;
                            if (take) begin
                                best_score <= $signed(bus.fc_out_data);
                            end
                        end
                        if (score_cnt_next > CNT_W'(FC_NUM_OUTPUTS)) begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (bus.fc_done && !fc_start_q) begin
                            done_q <= 1'b1;
                            if (score_cnt_next == CNT_W'(FC_NUM_OUTPUTS)) begin
                                state   <= S_FIN;
                                class_q <= best_idx_next;
                            end else begin
                                state   <= S_ERR;
                                error_q <= 1'b1;
                            end
                        end else if (wd_expired) begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_FIN, S_ERR: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.class_out  = class_q;
    assign bus.pix_ready  = pix_ready_q;
    assign bus.pix_we     = pix_we;
    assign bus.pix_addr   = pix_cnt;
    assign bus.conv_start = conv_start_q;
    assign bus.pool_start = pool_start_q;
    assign bus.fc_start   = fc_start_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - randomized scoreboard bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;
    localparam int NPIX = 784;
    localparam int NOUT = 10;
    localparam int TMO  = 4096;
    localparam int M_OK = 0, M_WD = 1, M_ABORT = 2, M_RST = 3;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    cnn_layer_sequencer_if bus ();
    cnn_layer_sequencer dut (.clk(clk), .rstb(rstb), .bus(bus));

    typedef struct {
        bit     err;
        int     cls;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    int     last_class = 0;
    int     conv_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rstb && bus.conv_start) conv_pulses++;
        if (!rstb && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_error", bus.error, mon_e.err);
                check("done_class", bus.class_out, mon_e.cls);
                if (mon_e.cyc >= 0) check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: a run succeeds only with exactly NOUT scores; class is the first maximum
    task automatic expect_fc(input int sc[11], input int n);
        exp_t e;
        int   best;
        e.cyc = -1;
        e.err = (n != NOUT);
        if (!e.err) begin
            best = 0;
            for (int i = 1; i < NOUT; i++) if (sc[i] > sc[best]) best = i;
            last_class = best;
        end
        e.cls = last_class;
        sb.push_back(e);
    endtask

    task automatic set_done(input int s, input logic v);
        case (s)
            0:       bus.conv_done = v;
            1:       bus.pool_done = v;
            default: bus.fc_done   = v;
        endcase
    endtask

    function automatic logic get_start(input int s);
        case (s)
            0:       return bus.conv_start;
            1:       return bus.pool_start;
            default: return bus.fc_start;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       bus.busy, 0);
        check({tag, "_done"},       bus.done, 0);
        check({tag, "_error"},      bus.error, 0);
        check({tag, "_class"},      bus.class_out, 0);
        check({tag, "_pix_ready"},  bus.pix_ready, 0);
        check({tag, "_pix_we"},     bus.pix_we, 0);
        check({tag, "_pix_addr"},   bus.pix_addr, 0);
        check({tag, "_conv_start"}, bus.conv_start, 0);
        check({tag, "_pool_start"}, bus.pool_start, 0);
        check({tag, "_fc_start"},   bus.fc_start, 0);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (bus.busy && k < limit) begin
            tick();
            k++;
        end
        check({name, "_idle"}, bus.busy, 0);
    endtask

    task automatic stage(input int s, input int d, input bit early, input int mode, output bit ended);
        exp_t   e;
        longint t0;
        ended = 1'b0;
        t0 = cyc;
        check($sformatf("start_pulse_%0d", s), get_start(s), 1);
        if (early) set_done(s, 1'b1);
        tick();
        set_done(s, 1'b0);
        check($sformatf("start_one_cycle_%0d", s), get_start(s), 0);
        check($sformatf("no_early_advance_%0d", s), get_start(s + 1), 0);
        if (mode == M_ABORT && s == 0) begin
            repeat (3) tick();
            bus.abort = 1'b1;
            bus.conv_done = 1'b1;
            tick();
            bus.abort = 1'b0;
            bus.conv_done = 1'b0;
            check("abort_busy", bus.busy, 0);
            check("abort_done", bus.done, 0);
            check("abort_beats_done", bus.pool_start, 0);
            check("abort_error", bus.error, 0);
            check("abort_class", bus.class_out, last_class);
            repeat (3) tick();
            ended = 1'b1;
            return;
        end
        if (mode == M_WD && s == 1) begin
            e.err = 1'b1;
            e.cls = last_class;
            e.cyc = t0 + TMO;
            sb.push_back(e);
            wait_idle(TMO + 100, "watchdog");
            check("watchdog_error_sticky", bus.error, 1);
            ended = 1'b1;
            return;
        end
        for (int k = 1; k < d; k++) begin
            set_done((s + 2) % 3, ($urandom_range(0, 3) == 0));
            tick();
        end
        set_done((s + 2) % 3, 1'b0);
        set_done(s, 1'b1);
        tick();
        set_done(s, 1'b0);
        check($sformatf("next_start_%0d", s), get_start(s + 1), 1);
    endtask

    task automatic fc_phase(input int mode, input int n, input int sc[11], input bit coincide);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (mode == M_RST && i == 4) begin
                bus.fc_out_valid = 1'b0;
                bus.fc_done = 1'b0;
                rstb = 1'b1;
                #1;
                check_reset_outputs("midrun_reset");
                tick();
                rstb = 1'b0;
                last_class = 0;
                return;
            end
            bus.fc_out_valid = 1'b1;
            bus.fc_out_data  = sc[i];
            if (coincide && i == n - 1 && n <= NOUT) bus.fc_done = 1'b1;
            tick();
            bus.fc_out_valid = 1'b0;
            bus.fc_done = 1'b0;
            if (i == NOUT) check("error_at_11th", bus.error, 1);
        end
        if (n <= NOUT && !coincide) begin
            repeat ($urandom_range(0, 2)) tick();
            bus.fc_done = 1'b1;
            tick();
            bus.fc_done = 1'b0;
        end
    endtask

    task automatic run(input int mode, input bit gapped, input int d0, input int d1, input int d2,
                       input bit early, input int n, input int sc[11], input bit coincide);
        int wrote, g, cp0;
        bit v, ended;
        if (mode == M_OK) expect_fc(sc, n);
        cp0 = conv_pulses;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ready_after_start", bus.pix_ready, 1);
        check("busy_after_start", bus.busy, 1);
        check("error_cleared_by_start", bus.error, 0);
        wrote = 0;
        g = 0;
        while (wrote < NPIX && g < 4 * NPIX) begin
            v = gapped ? (g % 2 == 0) : 1'b1;
            bus.pix_valid = v;
            bus.start = gapped && !v && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            check("pix_we", bus.pix_we, v);
            if (v) begin
                check("pix_addr", bus.pix_addr, wrote);
                wrote++;
            end
            tick();
            g++;
        end
        bus.pix_valid = 1'b0;
        bus.start = 1'b0;
        check("ready_after_load", bus.pix_ready, 0);
        stage(0, d0, early, mode, ended);
        if (!ended) stage(1, d1, 1'b0, mode, ended);
        if (!ended) begin
            repeat (d2) begin
                bus.conv_done = ($urandom_range(0, 3) == 0);
                bus.pool_done = ($urandom_range(0, 3) == 0);
                tick();
            end
            bus.conv_done = 1'b0;
            bus.pool_done = 1'b0;
            fc_phase(mode, n, sc, coincide);
        end
        wait_idle(50, "run");
        check("conv_start_once", conv_pulses - cp0, 1);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        int sc[11];
        bus.start = 0; bus.abort = 0; bus.pix_valid = 0;
        bus.conv_done = 0; bus.pool_done = 0; bus.fc_done = 0;
        bus.fc_out_valid = 0; bus.fc_out_data = '0;
        rstb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstb = 1'b0;
        tick();

        sc = '{5, -3, 9, 9, 0, 1, 2, 3, 4, -8, 0};
        run(M_OK, 1'b0, 20, 20, 0, 1'b0, NOUT, sc, 1'b0);
        check("nominal_class", bus.class_out, 2);
        check("nominal_error", bus.error, 0);

        for (int i = 0; i < 11; i++) sc[i] = int'($urandom);
        run(M_OK, 1'b1, 1, 7, 2, 1'b1, NOUT, sc, 1'b1);

        run(M_WD, 1'b0, 5, 0, 0, 1'b0, NOUT, sc, 1'b0);

        for (int i = 0; i < 11; i++) sc[i] = int'($urandom_range(0, 6)) - 3;
        run(M_OK, 1'b0, 3, 4, 1, 1'b0, NOUT, sc, 1'b0);

        run(M_OK, 1'b0, 2, 2, 0, 1'b0, 9, sc, 1'b0);
        check("fc9_error", bus.error, 1);
        run(M_OK, 1'b0, 2, 2, 0, 1'b0, 11, sc, 1'b0);

        for (int i = 0; i < 11; i++) sc[i] = -int'($urandom_range(2, 1000));
        sc[7] = -1;
        run(M_OK, 1'b1, 6, 3, 1, 1'b0, NOUT, sc, 1'b1);
        check("negative_argmax", bus.class_out, 7);

        run(M_ABORT, 1'b0, 10, 0, 0, 1'b0, NOUT, sc, 1'b0);
        run(M_RST, 1'b0, 4, 4, 0, 1'b0, NOUT, sc, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 11; i++)
                sc[i] = (r % 2 == 0) ? int'($urandom_range(0, 6)) - 3 : int'($urandom);
            run(M_OK, bit'($urandom_range(0, 1)), int'($urandom_range(1, 30)),
                int'($urandom_range(1, 30)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), NOUT, sc, bit'($urandom_range(0, 1)));
        end

        check("final_scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
